scarv_soc_periph_xbar: RTL and testbench

//  Parametrised peripheral-subsystem request router; successor to the fixed 2-device periph router.

---
 rtl/scarv_soc_periph_pkg.sv | 17 +
 rtl/scarv_soc_periph_txn_fifo.sv | 49 ++++
 rtl/scarv_soc_periph_xbar.sv | 167 ++++++++++++++++
 tb/tb_scarv_soc_periph_xbar.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_soc_periph_pkg.sv
// Shared constants and types for the peripheral request router.
package scarv_soc_periph_pkg;

  localparam int unsigned PERIPH_SLOT_LSB  = 12;
  localparam int unsigned PERIPH_SLOT_BITS = 4;
  localparam int unsigned PERIPH_WIN_LSB   = 16;
  localparam int unsigned PERIPH_ID_W      = PERIPH_SLOT_BITS + 1;

  // Widest possible transaction id: slot index plus the local-error code.
  typedef logic [PERIPH_ID_W-1:0] periph_id_t;

  // The local-error id sits one past the last device slot.
  function automatic periph_id_t periph_local_err(input int unsigned ndev);
    return PERIPH_ID_W'(ndev);
  endfunction

endpackage

// File: rtl/scarv_soc_periph_txn_fifo.sv
// In-order tracker of outstanding transaction ids; caller never pushes when full or pops when empty.
module scarv_soc_periph_txn_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge g_clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/scarv_soc_periph_xbar.sv
// Routes one requestor onto NDEV 4KB device slots, tracking in-order responses with local errors and timeouts.
module scarv_soc_periph_xbar
  import scarv_soc_periph_pkg::*;
#(
  parameter int unsigned NDEV        = 4,
  parameter logic [31:0] BASE        = 32'h1000_0000,
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 m_req,
  output logic                 m_gnt,
  input  logic                 m_wen,
  input  logic [3:0]           m_strb,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  output logic                 m_recv,
  input  logic                 m_ack,
  output logic                 m_error,
  output logic [31:0]          m_rdata,
  output logic [NDEV-1:0]      d_req,
  input  logic [NDEV-1:0]      d_gnt,
  output logic                 d_wen,
  output logic [3:0]           d_strb,
  output logic [31:0]          d_addr,
  output logic [31:0]          d_wdata,
  input  logic [NDEV-1:0]      d_recv,
  output logic [NDEV-1:0]      d_ack,
  input  logic [NDEV-1:0]      d_error,
  input  logic [32*NDEV-1:0]   d_rdata,
  output logic                 timeout_evt
);

  localparam int unsigned ID_W  = $clog2(NDEV + 1);
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ID_W-1:0] LOCAL_ERR = ID_W'(periph_local_err(NDEV));

  logic [PERIPH_SLOT_BITS-1:0] sel;
  logic                        hit;
  logic                        push, pop, full, empty;
  logic [ID_W-1:0]             push_id, head;
  logic                        head_dev, tmo_hit, tmo_fire;
  logic [TMR_W-1:0]            tcnt;
  logic [CNT_W-1:0]            orphan [NDEV];
  logic [NDEV-1:0]             orphan_inc, orphan_dec;

  assign d_wen   = m_wen;
  assign d_strb  = m_strb;
  assign d_addr  = m_addr;
  assign d_wdata = m_wdata;

  assign sel = m_addr[PERIPH_SLOT_LSB +: PERIPH_SLOT_BITS];
  assign hit = (m_addr[31:PERIPH_WIN_LSB] == BASE[31:PERIPH_WIN_LSB]) && (32'(sel) < NDEV);

  // Request path: zero-latency decode; misses are accepted locally.
  always_comb begin
    d_req   = '0;
    m_gnt   = 1'b0;
    push_id = LOCAL_ERR;
    if (!g_reset && !full) begin
      if (hit) begin
        push_id = ID_W'(sel);
        for (int unsigned i = 0; i < NDEV; i++) begin
          if (sel == PERIPH_SLOT_BITS'(i)) begin
            d_req[i] = m_req;
            m_gnt    = d_gnt[i];
          end
        end
      end else begin
        m_gnt = 1'b1;
      end
    end
  end

  assign push = m_req & m_gnt;

  scarv_soc_periph_txn_fifo #(
    .DEPTH (OUTSTANDING),
    .W     (ID_W)
  ) u_fifo (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .push    (push),
    .push_id (push_id),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign head_dev = !empty && (head != LOCAL_ERR);
  assign tmo_hit  = (TIMEOUT != 0) && (tcnt == TMR_W'(TIMEOUT));

  // Response path: head routing, orphan draining, and timeout substitution.
  always_comb begin
    m_recv     = 1'b0;
    m_error    = 1'b0;
    m_rdata    = '0;
    d_ack      = '0;
    orphan_inc = '0;
    orphan_dec = '0;
    tmo_fire   = 1'b0;
    if (!g_reset) begin
      for (int unsigned i = 0; i < NDEV; i++) begin
        if ((orphan[i] != '0) && d_recv[i]) begin
          d_ack[i]      = 1'b1;
          orphan_dec[i] = 1'b1;
        end
      end
      if (!empty && (head == LOCAL_ERR)) begin
        m_recv  = 1'b1;
        m_error = 1'b1;
      end else if (!empty) begin
        for (int unsigned i = 0; i < NDEV; i++) begin
          if (head == ID_W'(i)) begin
            if (orphan[i] == '0) begin
              d_ack[i] = m_ack;
              if (d_recv[i]) begin
                m_recv  = 1'b1;
                m_error = d_error[i];
                m_rdata = d_rdata[32*i +: 32];
              end
            end
            // A real response arriving on the timeout cycle takes priority.
            if (tmo_hit && !m_recv) begin
              m_recv        = 1'b1;
              m_error       = 1'b1;
              tmo_fire      = 1'b1;
              orphan_inc[i] = m_ack;
            end
          end
        end
      end
    end
  end

  assign pop         = m_recv & m_ack;
  assign timeout_evt = tmo_fire & m_ack;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      tcnt <= '0;
    end else if ((TIMEOUT == 0) || !head_dev || pop) begin
      tcnt <= '0;
    end else if (!tmo_hit) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Outstanding abandoned responses per device, saturating at the tracker depth.
  always_ff @(posedge g_clk) begin
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (g_reset) begin
        orphan[i] <= '0;
      end else begin
        case ({orphan_inc[i], orphan_dec[i]})
          2'b10:   if (orphan[i] != CNT_W'(OUTSTANDING)) orphan[i] <= orphan[i] + 1'b1;
          2'b01:   orphan[i] <= orphan[i] - 1'b1;
          default: orphan[i] <= orphan[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scarv_soc_periph_xbar.sv
// Directed bench for the peripheral router with a response scoreboard.
module tb_scarv_soc_periph_xbar;

  localparam int unsigned NDEV = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic               g_clk, g_reset;
  logic               m_req, m_gnt, m_wen, m_recv, m_ack, m_error;
  logic [3:0]         m_strb, d_strb;
  logic [31:0]        m_addr, m_wdata, m_rdata, d_addr, d_wdata;
  logic [NDEV-1:0]    d_req, d_gnt, d_recv, d_ack, d_error;
  logic               d_wen, timeout_evt;
  logic [32*NDEV-1:0] d_rdata;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t exp_next;

  scarv_soc_periph_xbar #(
    .NDEV        (NDEV),
    .BASE        (32'h1000_0000),
    .OUTSTANDING (4),
    .TIMEOUT     (16)
  ) dut (
    .g_clk       (g_clk),
    .g_reset     (g_reset),
    .m_req       (m_req),
    .m_gnt       (m_gnt),
    .m_wen       (m_wen),
    .m_strb      (m_strb),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_recv      (m_recv),
    .m_ack       (m_ack),
    .m_error     (m_error),
    .m_rdata     (m_rdata),
    .d_req       (d_req),
    .d_gnt       (d_gnt),
    .d_wen       (d_wen),
    .d_strb      (d_strb),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_recv      (d_recv),
    .d_ack       (d_ack),
    .d_error     (d_error),
    .d_rdata     (d_rdata),
    .timeout_evt (timeout_evt)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on request transfer, pop/compare on response transfer.
  always @(negedge g_clk) begin
    exp_t e;
    if (!g_reset && m_req && m_gnt) sb.push_back(exp_next);
    if (!g_reset && m_recv && m_ack) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL sb_unexpected: observed err=%b data=%h expected no response", m_error, m_rdata);
      end else begin
        e = sb.pop_front();
        assert ({m_error, m_rdata} === e) else begin
          errors++;
          $error("FAIL sb_resp: observed err=%b data=%h expected err=%b data=%h",
                 m_error, m_rdata, e.err, e.data);
        end
      end
    end
  end

  task automatic set_rdata(input int unsigned dev, input logic [31:0] val);
    d_rdata[32*dev +: 32] = val;
  endtask

  initial begin
    g_reset = 1'b1; m_req = 1'b0; m_wen = 1'b0; m_strb = 4'hF; m_addr = '0; m_wdata = '0;
    m_ack = 1'b0; d_gnt = '1; d_recv = '0; d_error = '0; d_rdata = '0; exp_next = '0;
    tick(); tick();

    // Reset holds every output low even with live inputs.
    m_req = 1'b1; m_addr = 32'h1000_0000; m_ack = 1'b1; d_recv = '1; set_rdata(0, 32'hDEAD_0000);
    #3;
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_dreq", 32'(d_req), 32'd0);
    chk("rst_recv", 32'(m_recv), 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_dack", 32'(d_ack), 32'd0);
    tick();
    g_reset = 1'b0; m_req = 1'b0; m_ack = 1'b0; d_recv = '0;

    // Back-to-back reads to slot0 and slot1.
    tick();
    m_req = 1'b1; m_addr = 32'h1000_0000; exp_next = '{1'b0, 32'hA000_0001};
    #3; chk("b2b_gnt0", 32'(m_gnt), 32'd1); chk("b2b_dreq0", 32'(d_req), 32'b0001);
    tick();
    m_addr = 32'h1000_1000; exp_next = '{1'b0, 32'hA000_0002};
    #3; chk("b2b_gnt1", 32'(m_gnt), 32'd1); chk("b2b_dreq1", 32'(d_req), 32'b0010);
    chk("b2b_wait", 32'(m_recv), 32'd0);
    tick();
    m_req = 1'b0; m_ack = 1'b1; d_recv = 4'b0001; set_rdata(0, 32'hA000_0001);
    #3; chk("b2b_rdata0", m_rdata, 32'hA000_0001); chk("b2b_dack0", 32'(d_ack), 32'b0001);
    tick();
    d_recv = 4'b0010; set_rdata(1, 32'hA000_0002);
    #3; chk("b2b_rdata1", m_rdata, 32'hA000_0002); chk("b2b_dack1", 32'(d_ack), 32'b0010);
    tick();
    d_recv = '0;
    #3; chk("b2b_empty", 32'(m_recv), 32'd0);

    // Unmapped slot answered locally.
    tick();
    m_ack = 1'b0; m_req = 1'b1; m_addr = 32'h1000_5000; exp_next = '{1'b1, 32'h0};
    #3; chk("miss_gnt", 32'(m_gnt), 32'd1); chk("miss_dreq", 32'(d_req), 32'd0);
    tick();
    m_req = 1'b0; m_ack = 1'b1;
    #3; chk("miss_recv", 32'(m_recv), 32'd1); chk("miss_err", 32'(m_error), 32'd1);
    tick();
    m_ack = 1'b0;

    // Fill the tracker with local-error requests, then hit the full limit.
    for (int k = 0; k < 4; k++) begin
      tick();
      m_req = 1'b1; m_addr = (k == 0) ? 32'h2000_0000 : 32'h1000_4000 + 32'(k) * 32'h1000;
      exp_next = '{1'b1, 32'h0};
      #3; chk("fill_gnt", 32'(m_gnt), 32'd1);
    end
    tick();
    m_addr = 32'h1000_0000;
    #3; chk("full_gnt", 32'(m_gnt), 32'd0); chk("full_dreq", 32'(d_req), 32'd0);
    tick();
    m_ack = 1'b1;
    #3; chk("full_pop_gnt", 32'(m_gnt), 32'd0);
    tick();
    m_addr = 32'h2000_0000; exp_next = '{1'b1, 32'h0};
    #3; chk("pushpop_gnt", 32'(m_gnt), 32'd1);
    tick();
    m_ack = 1'b0;
    #3; chk("refill_gnt", 32'(m_gnt), 32'd1);
    tick();
    #3; chk("refull_gnt", 32'(m_gnt), 32'd0);
    tick();
    m_req = 1'b0; m_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3; chk("drain_recv", 32'(m_recv), 32'd1);
      tick();
    end
    #3; chk("drain_empty", 32'(m_recv), 32'd0);

    // Silent device 2 times out after 16 cycles.
    tick();
    m_req = 1'b1; m_addr = 32'h1000_2000; exp_next = '{1'b1, 32'h0};
    #3; chk("tmo_dreq", 32'(d_req), 32'b0100);
    tick();
    m_req = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (k == 15) begin
        #3; chk("tmo_early", 32'(m_recv), 32'd0);
      end
    end
    tick();
    #3; chk("tmo_recv", 32'(m_recv), 32'd1); chk("tmo_err", 32'(m_error), 32'd1);
    chk("tmo_rdata", m_rdata, 32'd0); chk("tmo_evt", 32'(timeout_evt), 32'd1);
    tick();
    m_ack = 1'b0; d_recv = 4'b0100; set_rdata(2, 32'hBAD0_BAD0);
    #3; chk("tmo_evt_once", 32'(timeout_evt), 32'd0); chk("orph_dack", 32'(d_ack), 32'b0100);
    chk("orph_norecv", 32'(m_recv), 32'd0);
    tick();
    d_recv = '0; m_req = 1'b1; m_addr = 32'h1000_2000; exp_next = '{1'b0, 32'hC0DE_0002};
    #3; chk("dev2_gnt", 32'(m_gnt), 32'd1);
    tick();
    m_req = 1'b0; m_ack = 1'b1; d_recv = 4'b0100; set_rdata(2, 32'hC0DE_0002);
    #3; chk("dev2_rdata", m_rdata, 32'hC0DE_0002); chk("dev2_err", 32'(m_error), 32'd0);
    tick();
    d_recv = '0; m_ack = 1'b0;

    // Device 1 withholds grant for three cycles.
    m_req = 1'b1; m_addr = 32'h1000_1000; d_gnt = 4'b1101; exp_next = '{1'b0, 32'h5151_0001};
    for (int k = 0; k < 3; k++) begin
      #3; chk("stall_gnt", 32'(m_gnt), 32'd0); chk("stall_dreq", 32'(d_req), 32'b0010);
      tick();
    end
    d_gnt = '1;
    #3; chk("stall_release", 32'(m_gnt), 32'd1);
    tick();
    m_req = 1'b0; m_ack = 1'b1; d_recv = 4'b0010; set_rdata(1, 32'h5151_0001);
    #3; chk("stall_recv", 32'(m_recv), 32'd1);
    tick();
    d_recv = '0;
    #3; chk("stall_single", 32'(m_recv), 32'd0);

    // Reset with three transactions in flight.
    tick();
    m_ack = 1'b0; m_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_addr = 32'h1000_0000 + 32'(k) * 32'h1000; exp_next = '{1'b0, 32'hFFFF_FFFF};
      #3; chk("pre_rst_gnt", 32'(m_gnt), 32'd1);
      tick();
    end
    g_reset = 1'b1; sb.delete(); m_ack = 1'b1; d_recv = '1; set_rdata(0, 32'h1234_5678);
    #3;
    chk("mid_rst_gnt", 32'(m_gnt), 32'd0); chk("mid_rst_recv", 32'(m_recv), 32'd0);
    chk("mid_rst_err", 32'(m_error), 32'd0); chk("mid_rst_rdata", m_rdata, 32'd0);
    chk("mid_rst_dreq", 32'(d_req), 32'd0); chk("mid_rst_dack", 32'(d_ack), 32'd0);
    chk("mid_rst_evt", 32'(timeout_evt), 32'd0);
    tick();
    g_reset = 1'b0; m_req = 1'b0; d_recv = '0; m_ack = 1'b0;
    #3; chk("post_rst_empty", 32'(m_recv), 32'd0);
    tick();
    m_req = 1'b1; m_addr = 32'h1000_0000; exp_next = '{1'b0, 32'h0F0F_0F0F};
    #3; chk("post_rst_gnt", 32'(m_gnt), 32'd1);
    tick();
    m_req = 1'b0; m_ack = 1'b1; d_recv = 4'b0001; set_rdata(0, 32'h0F0F_0F0F);
    #3; chk("post_rst_rdata", m_rdata, 32'h0F0F_0F0F);
    tick();
    d_recv = '0; m_ack = 1'b0;
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
